// File: rtl/pfb_pkg.sv
// Shared defaults and types for the oversampled-PFB phase compensator.
// Pure declarations: no latency, no flow control.
package pfb_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int FFT_LEN_DEF = 64;
  localparam int DEC_FAC_DEF = 48;

  typedef logic [WIDTH_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DRAIN
  } rd_state_t;

endpackage

// File: rtl/pfb_sdp_ram.sv
// Simple dual-port RAM, one write and one read port, 1-cycle registered read.
// Read data holds while i_re is low; no flow control of its own.
module pfb_sdp_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdat
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdat;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
    if (i_re) r_rdat <= r_mem[i_raddr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/pfb_phasecomp.sv
// Ping-pong frame buffer applying the PFB circular-shift rotation; tvalid 2 cycles after a bank fills.
// Backpressure: a 2-entry skid absorbs RAM latency; s_axis_tready drops while both banks are occupied.
module pfb_phasecomp
  import pfb_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int FFT_LEN = FFT_LEN_DEF,
  parameter int DEC_FAC = DEC_FAC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [WIDTH-1:0]           m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [$clog2(FFT_LEN)-1:0] frame_shift
);

  localparam int            AW         = $clog2(FFT_LEN);
  localparam logic [AW-1:0] SHIFT_STEP = AW'(DEC_FAC % FFT_LEN);
  localparam logic [AW-1:0] LAST_IDX   = AW'(FFT_LEN - 1);

  bank_state_t      r_bank_st [2];
  rd_state_t        r_rd_st, w_rd_st_nxt;
  logic             r_live, r_wr_bank, r_rd_bank;
  logic [AW-1:0]    r_wr_cnt, r_rd_idx, r_shift, r_frame_shift;
  logic             r_p1_vld, r_p1_last;
  logic [1:0]       r_sk_cnt;
  logic [WIDTH-1:0] r_sk0_dat, r_sk1_dat;
  logic             r_sk0_last, r_sk1_last;

  logic             w_wr_fire, w_pop, w_credit, w_issue, w_start, w_frame_end, w_chain;
  logic [2:0]       w_occ;
  logic [AW-1:0]    w_rd_ofs;
  logic [WIDTH-1:0] w_ram_rdat;

  assign s_axis_tready = r_live &&
                         (r_bank_st[r_wr_bank] == EMPTY || r_bank_st[r_wr_bank] == FILLING);
  assign w_wr_fire     = s_axis_tvalid && s_axis_tready;
  assign w_pop         = m_axis_tvalid && m_axis_tready;
  // Entries in flight (RAM stage + skid) after this cycle's pop must leave room for one more.
  assign w_occ         = {1'b0, r_sk_cnt} + {2'b0, r_p1_vld} - {2'b0, w_pop};
  assign w_credit      = (w_occ < 3'd2);
  assign w_rd_ofs      = r_rd_idx + r_shift;

  always_comb begin
    w_rd_st_nxt = r_rd_st;
    w_issue     = 1'b0;
    w_start     = 1'b0;
    w_frame_end = 1'b0;
    w_chain     = 1'b0;
    case (r_rd_st)
      RD_IDLE: begin
        if (r_bank_st[r_rd_bank] == FULL) begin
          w_rd_st_nxt = RD_DRAIN;
          w_start     = 1'b1;
          w_issue     = w_credit;
        end
      end
      RD_DRAIN: begin
        w_issue = w_credit;
        if (w_credit && r_rd_idx == LAST_IDX) begin
          w_frame_end = 1'b1;
          w_chain     = (r_bank_st[~r_rd_bank] == FULL);
          if (!w_chain) w_rd_st_nxt = RD_IDLE;
        end
      end
      default: w_rd_st_nxt = RD_IDLE;
    endcase
  end

  // Write and read sides never touch the same bank on one edge: their bank states are disjoint.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live        <= 1'b0;
      r_rd_st       <= RD_IDLE;
      r_bank_st[0]  <= EMPTY;
      r_bank_st[1]  <= EMPTY;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_wr_cnt      <= '0;
      r_rd_idx      <= '0;
      r_shift       <= '0;
      r_frame_shift <= '0;
    end else begin
      r_live  <= 1'b1;
      r_rd_st <= w_rd_st_nxt;
      if (w_wr_fire) begin
        if (r_wr_cnt == LAST_IDX) begin
          r_bank_st[r_wr_bank] <= FULL;
          r_wr_bank            <= ~r_wr_bank;
          r_wr_cnt             <= '0;
        end else begin
          r_bank_st[r_wr_bank] <= FILLING;
          r_wr_cnt             <= r_wr_cnt + 1'b1;
        end
      end
      if (w_start) begin
        r_bank_st[r_rd_bank] <= DRAINING;
        r_frame_shift        <= r_shift;
      end
      if (w_issue) r_rd_idx <= r_rd_idx + 1'b1;
      if (w_frame_end) begin
        r_bank_st[r_rd_bank] <= EMPTY;
        r_rd_bank            <= ~r_rd_bank;
        r_shift              <= r_shift + SHIFT_STEP;
        if (w_chain) begin
          r_bank_st[~r_rd_bank] <= DRAINING;
          r_frame_shift         <= r_shift + SHIFT_STEP;
        end
      end
    end
  end

  pfb_sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (2 * FFT_LEN),
    .AW    (AW + 1)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_fire),
    .i_waddr ({r_wr_bank, r_wr_cnt}),
    .i_wdat  (s_axis_tdata),
    .i_re    (w_issue),
    .i_raddr ({r_rd_bank, w_rd_ofs}),
    .o_rdat  (w_ram_rdat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p1_vld   <= 1'b0;
      r_p1_last  <= 1'b0;
      r_sk_cnt   <= 2'd0;
      r_sk0_dat  <= '0;
      r_sk1_dat  <= '0;
      r_sk0_last <= 1'b0;
      r_sk1_last <= 1'b0;
    end else begin
      r_p1_vld  <= w_issue;
      r_p1_last <= w_issue && (r_rd_idx == LAST_IDX);
      case (r_sk_cnt)
        2'd0: begin
          if (r_p1_vld) begin
            r_sk0_dat  <= w_ram_rdat;
            r_sk0_last <= r_p1_last;
            r_sk_cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (r_p1_vld && w_pop) begin
            r_sk0_dat  <= w_ram_rdat;
            r_sk0_last <= r_p1_last;
          end else if (r_p1_vld) begin
            r_sk1_dat  <= w_ram_rdat;
            r_sk1_last <= r_p1_last;
            r_sk_cnt   <= 2'd2;
          end else if (w_pop) begin
            r_sk_cnt <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_sk0_dat  <= r_sk1_dat;
            r_sk0_last <= r_sk1_last;
            if (r_p1_vld) begin
              r_sk1_dat  <= w_ram_rdat;
              r_sk1_last <= r_p1_last;
            end else begin
              r_sk_cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign m_axis_tvalid = (r_sk_cnt != 2'd0);
  assign m_axis_tdata  = r_sk0_dat;
  assign m_axis_tlast  = r_sk0_last && m_axis_tvalid;
  assign frame_shift   = r_frame_shift;

endmodule

// File: tb/tb_pfb_phasecomp.sv
// Directed bench for pfb_phasecomp (M=8): rotation per frame, latency, backpressure, reset.
// A second instance with DEC_FAC=8 shares the inputs and must pass frames unrotated.
module tb_pfb_phasecomp;
  import pfb_pkg::*;

  localparam int M = 8;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  sample_t s_axis_tdata = '0;
  logic    s_axis_tvalid = 1'b0;
  logic    s_axis_tready;
  sample_t m_axis_tdata;
  logic    m_axis_tvalid;
  logic    m_axis_tready = 1'b1;
  logic    m_axis_tlast;
  logic [2:0] frame_shift;

  logic    s8_tready;
  sample_t m8_tdata;
  logic    m8_tvalid;
  logic    m8_tlast;
  logic [2:0] fs8;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    sample_t d;
    logic    l;
    int      c;
  } beat_t;

  beat_t q_out[$];
  beat_t q8[$];

  pfb_phasecomp #(.WIDTH(16), .FFT_LEN(M), .DEC_FAC(6)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_shift   (frame_shift)
  );

  pfb_phasecomp #(.WIDTH(16), .FFT_LEN(M), .DEC_FAC(8)) u_dut8 (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s8_tready),
    .m_axis_tdata  (m8_tdata),
    .m_axis_tvalid (m8_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m8_tlast),
    .frame_shift   (fs8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output capture plus hold-while-stalled check.
  logic    p_stall = 1'b0;
  sample_t p_dat   = '0;
  logic    p_last  = 1'b0;
  always @(negedge clk) begin
    beat_t b;
    if (rst && p_stall) begin
      chk("hold_vld", m_axis_tvalid, 1);
      chk("hold_dat", m_axis_tdata, p_dat);
      chk("hold_last", m_axis_tlast, p_last);
    end
    p_stall = rst && m_axis_tvalid && !m_axis_tready;
    p_dat   = m_axis_tdata;
    p_last  = m_axis_tlast;
    if (rst && m_axis_tvalid && m_axis_tready) begin
      b.d = m_axis_tdata; b.l = m_axis_tlast; b.c = cyc;
      q_out.push_back(b);
    end
    if (rst && m8_tvalid && m_axis_tready) begin
      b.d = m8_tdata; b.l = m8_tlast; b.c = cyc;
      q8.push_back(b);
    end
  end

  task automatic do_reset();
    rst = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_rdy", s_axis_tready, 0);
    chk("rst_m_vld", m_axis_tvalid, 0);
    chk("rst_m_last", m_axis_tlast, 0);
    chk("rst_m_dat", m_axis_tdata, 0);
    chk("rst_fshift", frame_shift, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    q_out.delete(); q8.delete();
    chk("rel_s_rdy_pre", s_axis_tready, 0);
    @(posedge clk); #1;
    chk("rel_s_rdy_post", s_axis_tready, 1);
  endtask

  task automatic feed(input int base, input int n, input int vpct, input bit rnd_rdy);
    int k = 0;
    int g = 0;
    while (k < n && g < 5000) begin
      s_axis_tvalid = (int'($urandom_range(99)) < vpct);
      s_axis_tdata  = sample_t'(base + k);
      if (rnd_rdy) m_axis_tready = 1'($urandom_range(1));
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) k++;
      @(posedge clk); #1;
      g++;
    end
    s_axis_tvalid = 1'b0;
    chk("feed_count", k, n);
  endtask

  task automatic wait_beats(input int n, input bit rnd_rdy);
    int g = 0;
    while (q_out.size() < n && g < 4000) begin
      if (rnd_rdy) m_axis_tready = 1'($urandom_range(1));
      @(posedge clk); #1;
      g++;
    end
    m_axis_tready = 1'b1;
    chk("beat_count", q_out.size(), n);
  endtask

  // Frame k of the input stream emerges rotated left by (k*step) mod M.
  task automatic chk_frames(input int base, input int nfr, input int step, input bit sel8);
    for (int k = 0; k < nfr; k++) begin
      for (int i = 0; i < M; i++) begin
        int    n;
        int    ev;
        beat_t b;
        n  = k * M + i;
        ev = base + k * M + ((i + (k * step) % M) % M);
        b  = sel8 ? q8[n] : q_out[n];
        chk(sel8 ? "dat8" : "dat", b.d, ev);
        chk(sel8 ? "last8" : "last", b.l, (i == M - 1));
      end
    end
  endtask

  int exp2[32] = '{0, 1, 2, 3, 4, 5, 6, 7,
                   14, 15, 8, 9, 10, 11, 12, 13,
                   20, 21, 22, 23, 16, 17, 18, 19,
                   26, 27, 28, 29, 30, 31, 24, 25};

  initial begin
    int acc;

    // 1: single frame, latency and unrotated output
    do_reset();
    feed(0, 8, 100, 0);
    chk("t1_vld_n0", m_axis_tvalid, 0);
    @(posedge clk); #1;
    chk("t1_vld_n1", m_axis_tvalid, 0);
    @(posedge clk); #1;
    chk("t1_vld_n2", m_axis_tvalid, 1);
    chk("t1_dat0", m_axis_tdata, 0);
    chk("t1_fshift", frame_shift, 0);
    wait_beats(8, 0);
    chk_frames(0, 1, 6, 0);

    // 2: continuous stream, shifts 0/6/4/2, back-to-back frames
    do_reset();
    feed(0, 32, 100, 0);
    wait_beats(32, 0);
    for (int i = 0; i < 32; i++) begin
      chk("t2_dat", q_out[i].d, exp2[i]);
      chk("t2_last", q_out[i].l, (i % M == M - 1));
      if (i > 0) chk("t2_gap", q_out[i].c - q_out[i-1].c, 1);
    end

    // 3: output stalled, input fills both banks then stops
    do_reset();
    m_axis_tready = 1'b0;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = sample_t'(acc);
      @(negedge clk);
      if (s_axis_tready) acc++;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    chk("t3_accepted", acc, 16);
    chk("t3_s_rdy", s_axis_tready, 0);
    chk("t3_m_vld", m_axis_tvalid, 1);
    chk("t3_m_dat", m_axis_tdata, 0);
    chk("t3_m_last", m_axis_tlast, 0);
    m_axis_tready = 1'b1;
    wait_beats(16, 0);
    chk_frames(0, 2, 6, 0);
    chk("t3_fshift", frame_shift, 6);

    // 4: random valid and ready over 40 frames
    do_reset();
    feed(0, 40 * M, 50, 1);
    wait_beats(40 * M, 1);
    chk_frames(0, 40, 6, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("t4_no_extra", q_out.size(), 40 * M);

    // 5: reset while frame 0 drains and frame 1 is partly written
    do_reset();
    feed(0, 8, 100, 0);
    feed(8, 5, 100, 0);
    chk("t5_pre_vld", m_axis_tvalid, 1);
    rst = 1'b0;
    #1;
    chk("t5_m_vld", m_axis_tvalid, 0);
    chk("t5_m_last", m_axis_tlast, 0);
    chk("t5_m_dat", m_axis_tdata, 0);
    chk("t5_fshift", frame_shift, 0);
    chk("t5_s_rdy", s_axis_tready, 0);
    do_reset();
    feed(100, 8, 100, 0);
    wait_beats(8, 0);
    chk_frames(100, 1, 6, 0);
    chk("t5_fshift_after", frame_shift, 0);

    // 6: critically sampled instance never rotates
    do_reset();
    chk("t6_s8_rdy", s8_tready, 1);
    feed(0, 24, 100, 0);
    chk("t6_fs8_mid", fs8, 0);
    wait_beats(24, 0);
    chk("t6_count8", q8.size(), 24);
    chk_frames(0, 3, 8, 1);
    chk("t6_fs8_end", fs8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pfb_phasecomp.md
Name: pfb_phasecomp

Overview:
- Sits directly downstream of the FIR processing-element chain; consumes its summed output stream (m_axis_sum) one FFT frame at a time.
- Applies the oversampled-PFB circular-shift phase compensation, then streams the reordered frame to the FFT.
- Ping-pong buffer: one bank fills from the FIR while the other drains, rotated, to the FFT.

Parameters:
- WIDTH, 16, sample width in bits; matches FIR sum width.
- FFT_LEN, 64, frame length M; power of two, >= 4.
- DEC_FAC, 48, decimation factor D; 0 < D <= M.
- AW, $clog2(FFT_LEN), derived index width; not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  WIDTH  FIR sum sample.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  WIDTH  phase-compensated sample to the FFT.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  FFT ready.
- m_axis_tlast  out  1  high on the last sample of each output frame.
- frame_shift  out  AW  rotation applied to the frame currently draining.

Behaviour:
- Reset, asserted asynchronously: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_shift=0. Both banks EMPTY, counters 0, shift=0. Partial frames are discarded.
- s_axis_tready goes to 1 on the first clock edge after reset release.
- Bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - Samples are accepted on s_axis_tvalid && s_axis_tready and written sequentially at address wr_cnt into the write bank.
  - When the sample at wr_cnt=M-1 is accepted, the bank becomes FULL and the write pointer toggles to the other bank.
  - s_axis_tready = (the write bank is EMPTY or FILLING). It drops when both banks are occupied.
- Read FSM: IDLE, DRAIN.
  - IDLE -> DRAIN when the read bank is FULL. On that transition frame_shift <= shift.
  - In DRAIN, the address for output index i (0..M-1) is (i + shift) mod M (AW-bit natural wrap). It advances only when the output pipeline can take a sample.
  - After index M-1 is issued: shift <= (shift + DEC_FAC) mod M, the bank becomes EMPTY, and the read pointer toggles.
  - If the other bank is already FULL, the FSM stays in DRAIN and issues its index 0 on the next cycle: no bubble between frames. Otherwise it returns to IDLE.
- Latency: a bank becomes FULL at edge N. The RAM address is issued at N+1 and m_axis_tvalid is high from N+2 (1-cycle synchronous RAM read plus output register).
- Output:
  - A 2-entry skid/output register isolates RAM read latency from m_axis_tready.
  - m_axis_tdata and m_axis_tlast stay stable while m_axis_tvalid && !m_axis_tready.
  - m_axis_tlast is high only with output index M-1.
- Throughput: with m_axis_tready=1 and continuous input, one sample per cycle is sustained in both directions indefinitely.
- Simultaneous events:
  - The write into one bank and the read from the other bank in the same cycle are always legal.
  - A bank freed (EMPTY) on the same edge the write side needs it is usable on the next cycle. s_axis_tready may be combinationally recomputed from registered state only.
- Reset mid-frame: everything clears. The first frame after reset uses shift 0.

Decomposition:
- Package pfb_pkg: WIDTH, FFT_LEN, DEC_FAC defaults; sample_t (logic [WIDTH-1:0]); bank_state_t enum (EMPTY, FILLING, FULL, DRAINING); read FSM state enum.
- One sub-module: pfb_sdp_ram, a simple dual-port RAM with depth 2*FFT_LEN, bank select as address MSB, and 1-cycle registered read.

Test Plan (FFT_LEN=8, DEC_FAC=6, m_axis_tready=1 unless stated):
1. Reset, then feed 0..7 -> output 0,1,2,3,4,5,6,7; tlast on 7; first tvalid 2 cycles after sample 7 accepted; frame_shift=0.
2. Continuous feed 0..31 -> frame1 outputs 14,15,8,9,10,11,12,13 (shift 6); frame2 outputs 20,21,22,23,16,17,18,19 (shift 4); frame3 shift 2 -> 26,27,...,25; no idle cycle between frames.
3. m_axis_tready=0, continuous input -> exactly 16 samples accepted, then s_axis_tready=0. m_axis_tvalid held with m_axis_tdata=0. Raising tready drains 0..7 then 14,15,8..13.
4. Random m_axis_tready (50%) and random s_axis_tvalid over 40 frames -> output equals reference model: circular rotation by (k*6 mod 8) for frame k. No duplicated or lost samples; tlast every 8th beat.
5. Assert rst after 5 samples of frame 1 while frame 0 is draining -> all outputs drop to reset values. The next input 100..107 emerges as 100..107 (shift 0).
6. DEC_FAC=8 (critically sampled) -> every frame is passed unrotated; frame_shift stays 0.
